// File: rtl/demux1x4_fifo_pkg.sv
// Shared definitions for the 1-to-4 result distributor.
//   DATA_W_DEF : default word width
//   DEPTH_DEF  : default entries per channel FIFO
//   N_CANALES  : number of destination channels
//   SEL_W      : width of the destination tag
//   CAN_*      : SEL encoding of each destination
package demux1x4_fifo_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;
  localparam int N_CANALES  = 4;
  localparam int SEL_W      = 2;

  localparam logic [SEL_W-1:0] CAN_RF  = 2'b00;
  localparam logic [SEL_W-1:0] CAN_MEM = 2'b01;
  localparam logic [SEL_W-1:0] CAN_IO  = 2'b10;
  localparam logic [SEL_W-1:0] CAN_DBG = 2'b11;
endpackage

// File: rtl/demux1x4_fifo_if.sv
// Bus bundle of the distributor: tagged input stream plus four output channels.
//   SEL/in_data/in_valid/in_ready : input word, destination tag, handshake
//   out_data/out_valid/out_ready  : channel k at slice k of each vector
//   ocup                          : per-channel occupancy, OCC_W bits each
// slave is the distributor side, master is the producer/consumer side.
interface demux1x4_fifo_if
  import demux1x4_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OCC_W  = 2
);
  logic [SEL_W-1:0]            SEL;
  logic [DATA_W-1:0]           in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [N_CANALES*DATA_W-1:0] out_data;
  logic [N_CANALES-1:0]        out_valid;
  logic [N_CANALES-1:0]        out_ready;
  logic [N_CANALES*OCC_W-1:0]  ocup;

  modport slave (
    input  SEL, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, ocup
  );

  modport master (
    output SEL, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, ocup
  );
endinterface

// File: rtl/demux1x4_fifo_fifo_canal.sv
// Single-channel synchronous FIFO with registered head word.
//   clk, reset : system clock, async active-high reset
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop head word (ignored when empty)
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_occ      : current occupancy
//   o_head     : head word; holds the last head when empty, 0 after reset
module fifo_canal #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [OCC_W-1:0]  o_occ,
  output logic [DATA_W-1:0] o_head
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [DATA_W-1:0] r_head;

  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rd_nxt;

  assign o_full   = (r_occ == OCC_W'(DEPTH));
  assign o_empty  = (r_occ == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign w_rd_nxt = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= w_rd_nxt;

      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);

      // Head register tracks the entry at the read pointer after this edge.
      // When the FIFO is (or becomes) empty it keeps its old value.
      if (w_push && o_empty)
        r_head <= i_data;
      else if (w_pop && w_push && r_occ == OCC_W'(1))
        r_head <= i_data;  // sole entry leaves while the new word lands behind it
      else if (w_pop && r_occ > OCC_W'(1))
        r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_head;
endmodule

// File: rtl/demux1x4_fifo.sv
// Registered 1-to-4 result distributor. Each accepted word is steered by SEL
// into one of four channel FIFOs (register file, memory buffer, I/O, debug).
//   clk, reset : system clock, async active-high reset
//   bus        : slave side of demux1x4_fifo_if (input stream, four outputs)
// in_ready depends only on stored state and SEL, never on out_ready.
module demux1x4_fifo
  import demux1x4_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic             clk,
  input logic             reset,
  demux1x4_fifo_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [N_CANALES-1:0]        w_full;
  logic [N_CANALES-1:0]        w_empty;
  logic [N_CANALES-1:0]        w_push;
  logic [OCC_W-1:0]            w_occ  [N_CANALES];
  logic [DATA_W-1:0]           w_head [N_CANALES];
  logic [N_CANALES*OCC_W-1:0]  w_ocup;
  logic [N_CANALES*DATA_W-1:0] w_out_data;

  for (genvar k = 0; k < N_CANALES; k++) begin : g_canal
    assign w_push[k] = bus.in_valid && (bus.SEL == SEL_W'(k)) && !w_full[k];

    fifo_canal #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[k]),
      .i_data  (bus.in_data),
      .i_pop   (bus.out_ready[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_occ   (w_occ[k]),
      .o_head  (w_head[k])
    );
  end

  always_comb begin
    w_ocup     = '0;
    w_out_data = '0;
    for (int k = 0; k < N_CANALES; k++) begin
      w_ocup[k*OCC_W +: OCC_W]       = w_occ[k];
      w_out_data[k*DATA_W +: DATA_W] = w_head[k];
    end
  end

  assign bus.in_ready  = !w_full[bus.SEL];
  assign bus.out_valid = ~w_empty;
  assign bus.ocup      = w_ocup;
  assign bus.out_data  = w_out_data;
endmodule

// File: tb/tb_demux1x4_fifo.sv
module tb_demux1x4_fifo;
  import demux1x4_fifo_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  demux1x4_fifo_if #(.DATA_W(DATA_W), .OCC_W(OCC_W)) bus_if ();

  demux1x4_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel word queue is the FIFO contents.
  int          cnt [4];
  logic [31:0] sb  [4][$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model update at each edge: push acceptance is judged on the pre-edge fill.
  always @(posedge clk or posedge reset) begin
    int  s;
    bit  rdy;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k] = 0;
        sb[k].delete();
      end
    end else begin
      s   = int'(bus_if.SEL);
      rdy = (cnt[s] < DEPTH);
      for (int k = 0; k < 4; k++)
        if (cnt[k] > 0 && bus_if.out_ready[k]) cnt[k]--;
      if (bus_if.in_valid && rdy) begin
        cnt[s]++;
        sb[s].push_back(bus_if.in_data);
      end
    end
  end

  // Monitor: compare outputs mid-cycle, retire words that leave at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 128'(bus_if.in_ready), 128'(cnt[bus_if.SEL] < DEPTH));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), 128'(bus_if.out_valid[k]), 128'(cnt[k] > 0));
        chk($sformatf("ocup[%0d]", k), 128'(bus_if.ocup[k*OCC_W +: OCC_W]), 128'(cnt[k]));
        if (bus_if.out_valid[k]) begin
          if (sb[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_data[%0d]: valid word %0h with empty scoreboard", k,
                     bus_if.out_data[k*DATA_W +: DATA_W]);
          end else begin
            chk($sformatf("out_data[%0d]", k), 128'(bus_if.out_data[k*DATA_W +: DATA_W]),
                128'(sb[k][0]));
          end
        end
        if (cnt[k] > 0 && bus_if.out_ready[k] && sb[k].size() > 0)
          void'(sb[k].pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
    bus_if.in_valid  = v;
    bus_if.SEL       = s;
    bus_if.in_data   = d;
    bus_if.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  i;
    bit  acc;
    bus_if.in_valid  = 1'b0;
    bus_if.SEL       = 2'b00;
    bus_if.in_data   = '0;
    bus_if.out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(bus_if.out_valid), 128'(4'b0000));
    chk("rst_ocup", 128'(bus_if.ocup), 128'(0));
    chk("rst_in_ready", 128'(bus_if.in_ready), 128'(1'b1));
    chk("rst_out_data", 128'(bus_if.out_data), 128'(0));
    drive(0, 0, 0, 4'b0000);

    // routing and latency
    drive(1, CAN_IO, 32'hDEAD_BEEF, 4'b0000);
    chk("route_valid", 128'(bus_if.out_valid), 128'(4'b0100));
    chk("route_data", 128'(bus_if.out_data[95:64]), 128'(32'hDEAD_BEEF));
    chk("route_ocup2", 128'(bus_if.ocup[5:4]), 128'(1));
    chk("route_ocup_other", 128'({bus_if.ocup[7:6], bus_if.ocup[3:0]}), 128'(0));
    drive(0, 0, 0, 4'b0100);

    // full and back-pressure, then switch SEL while stalled
    drive(1, CAN_RF, 32'h1, 4'b0000);
    drive(1, CAN_RF, 32'h2, 4'b0000);
    bus_if.in_valid = 1'b1;
    bus_if.SEL      = CAN_RF;
    bus_if.in_data  = 32'h3;
    #1;
    chk("full_ready0", 128'(bus_if.in_ready), 128'(1'b0));
    chk("full_ocup0", 128'(bus_if.ocup[1:0]), 128'(2));
    bus_if.SEL = CAN_MEM;
    #1;
    chk("switch_ready1", 128'(bus_if.in_ready), 128'(1'b1));
    drive(1, CAN_MEM, 32'h3, 4'b0000);
    chk("switch_ocup1", 128'(bus_if.ocup[3:2]), 128'(1));
    chk("switch_data1", 128'(bus_if.out_data[63:32]), 128'(32'h3));

    // full with simultaneous pop: push refused, then accepted next cycle
    drive(1, CAN_RF, 32'h4, 4'b0001);
    chk("fullpop_ocup0", 128'(bus_if.ocup[1:0]), 128'(1));
    chk("fullpop_head0", 128'(bus_if.out_data[31:0]), 128'(32'h2));
    drive(1, CAN_RF, 32'h4, 4'b0001);
    chk("fullpop2_ocup0", 128'(bus_if.ocup[1:0]), 128'(1));
    chk("fullpop2_head0", 128'(bus_if.out_data[31:0]), 128'(32'h4));
    drive(0, 0, 0, 4'b1111);

    // wrap-around on channel 3 with toggling out_ready
    i = 0;
    for (int c = 0; c < 100 && i < 10; c++) begin
      acc = (cnt[3] < DEPTH);
      drive(1, CAN_DBG, 32'h10 + 32'(i), (c % 2 == 0) ? 4'b1000 : 4'b0000);
      if (acc) i++;
    end
    chk("wrap_all_sent", 128'(i), 128'(10));
    repeat (3) drive(0, 0, 0, 4'b1000);
    chk("wrap_drained", 128'(bus_if.out_valid[3]), 128'(1'b0));

    // concurrent pops on all channels plus a push on channel 1
    drive(1, CAN_RF,  32'hA0, 4'b0000);
    drive(1, CAN_MEM, 32'hA1, 4'b0000);
    drive(1, CAN_IO,  32'hA2, 4'b0000);
    drive(1, CAN_DBG, 32'hA3, 4'b0000);
    chk("conc_full_valid", 128'(bus_if.out_valid), 128'(4'b1111));
    drive(1, CAN_MEM, 32'hAA, 4'b1111);
    chk("conc_valid", 128'(bus_if.out_valid), 128'(4'b0010));
    chk("conc_ocup", 128'(bus_if.ocup), 128'(8'b0000_0100));
    chk("conc_data1", 128'(bus_if.out_data[63:32]), 128'(32'hAA));
    drive(0, 0, 0, 4'b1111);

    // reset mid-operation with data stored
    drive(1, CAN_RF, 32'h55, 4'b0000);
    drive(1, CAN_IO, 32'h66, 4'b0000);
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(bus_if.out_valid), 128'(4'b0000));
    chk("midrst_ocup", 128'(bus_if.ocup), 128'(0));
    chk("midrst_in_ready", 128'(bus_if.in_ready), 128'(1'b1));
    chk("midrst_out_data", 128'(bus_if.out_data), 128'(0));
    drive(0, 0, 0, 4'b0000);
    reset = 1'b0;
    drive(0, 0, 0, 4'b0000);

    // randomized traffic
    repeat (400)
      drive(1'($urandom_range(0, 1)), 2'($urandom), $urandom, 4'($urandom));
    repeat (4) drive(0, 0, 0, 4'b1111);
    chk("final_empty", 128'(bus_if.out_valid), 128'(4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux1x4_fifo.md
Name: demux1x4_fifo

Overview:
- Registered 1-to-4 result distributor: inverse of the datapath 4-input selector.
- Takes one 32-bit word stream with a 2-bit SEL tag and steers each accepted word to one of four destination channels.
- Each channel has its own small FIFO and a valid/ready handshake.
- Sits between the execute/write-back result path and the four consumers (register file write port, memory write buffer, I/O port, debug trace).

Parameters:
- DATA_W, 32, word width of input and of each output channel.
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
- OCC_W, $clog2(DEPTH+1), width of each occupancy field (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- SEL  in  2  destination channel of the current input word.
- in_data  in  DATA_W  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the word on SEL this cycle.
- out_data  out  4*DATA_W  channel k head word at bits [k*DATA_W +: DATA_W].
- out_valid  out  4  bit k: channel k FIFO non-empty.
- out_ready  in  4  bit k: consumer k takes the head word.
- ocup  out  4*OCC_W  channel k occupancy at [k*OCC_W +: OCC_W].

Behaviour:
- Reset (async assert, released synchronously to clk): all FIFOs empty; out_valid=0, out_data=0, ocup=0. in_ready=1 after reset, because no FIFO is full.
- in_ready is purely combinational: NOT full[SEL]. It depends only on registered state and SEL, never on out_ready, so no ready path runs through the block.
- Push: on a clk edge with in_valid && in_ready, in_data is written to FIFO[SEL] at its write pointer. Only that channel's write pointer and occupancy change.
- Pop: on a clk edge with out_valid[k] && out_ready[k], FIFO k's read pointer advances and its occupancy decrements. All four channels may pop in the same cycle.
- Latency: a word accepted at edge N appears on out_data[k] with out_valid[k]=1 after edge N, i.e. usable in cycle N+1. Minimum latency is 1 cycle and there is no bypass path.
- Simultaneous push and pop on the same channel:
  - Occupancy is unchanged.
  - If the channel was empty, only the push applies; the pop is impossible because out_valid=0.
  - If the channel is full, the push is blocked (in_ready=0) even if out_ready=1 that cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full means ocup==DEPTH; empty means ocup==0.
- out_data[k] is the registered head entry. It holds its last value when empty, or 0 if the FIFO has never been written since reset. Consumers sample it only when out_valid[k]=1.
- Ordering: words on the same channel leave in acceptance order. There is no ordering guarantee across channels.
- SEL and in_data are only meaningful when in_valid=1. With in_valid=0 no state changes occur, whatever SEL is.
- A stalled sender may change SEL while in_valid=1. in_ready then re-evaluates for the new channel; no word is lost or duplicated.
- Reset mid-operation: all stored words are discarded and all pointers and occupancies go to 0 immediately. Data in flight is not recovered.

Decomposition:
- Shared package holds: DATA_W default, N_CANALES=4, SEL width 2, and a SEL encoding localparam per destination (CAN_RF=2'b00, CAN_MEM=2'b01, CAN_IO=2'b10, CAN_DBG=2'b11).
- One sub-module, fifo_canal:
  - a single synchronous FIFO with push/pop, full, empty, occupancy and head data;
  - parameterised by DATA_W and DEPTH;
  - instantiated four times by generate.
- The top level holds only SEL decode, the in_ready mux and the output concatenation.

Test Plan:
- Reset check: assert reset mid-simulation with the FIFOs holding data -> out_valid=4'b0000, ocup=0, in_ready=1 in the same cycle, without waiting for a clock edge.
- Routing and latency: push SEL=2'b10, in_data=32'hDEAD_BEEF at edge N with out_ready=0 -> at N+1 out_valid=4'b0100, out_data[95:64]=32'hDEADBEEF, ocup[2]=1; other channels unchanged.
- Full and back-pressure: with out_ready=0, push 32'h1 then 32'h2 on SEL=0 -> ocup[0]=2 and in_ready=0 for SEL=0.
  - Switching SEL=1 -> in_ready=1 and 32'h3 is accepted into channel 1.
- Full with simultaneous pop: channel 0 full, out_ready[0]=1, in_valid=1, SEL=0 -> push refused; head 32'h1 pops and ocup[0]=1.
  - Next cycle the push is accepted -> out order 32'h2, then the new word.
- Wrap-around: stream 10 words 32'h10..32'h19 on SEL=3 with out_ready[3] toggling 1,0,1,0 -> all 10 words emerge in order, no loss or duplication, ocup[3] never exceeds 2.
- Concurrent pops: all four channels hold one word and out_ready=4'b1111 -> after one edge out_valid=4'b0000, ocup=0.
  - A push on SEL=1 in that same cycle -> out_valid=4'b0010 at the next cycle.
